dm_bus_arbiter: RTL and testbench

- Shares the single data-memory/bridge port between two masters: the CPU M stage and an auxiliary master (DMA/debug loader).
- Sits between the CPU data port and the Bridge; the Bridge sees one master only.
- Ownership is parked on the CPU, so uncontested CPU accesses add zero latency.
- The aux master gets bounded-latency service through a starvation counter and bounded burst tenure.

---
 rtl/dm_bus_arbiter_pkg.sv | 7 +
 rtl/dm_arb_mux.sv | 27 ++
 rtl/dm_bus_arbiter.sv | 108 ++++++++++
 tb/tb_dm_bus_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// dm_bus_arbiter_pkg: owner encodings, parameter defaults and byte-enable constants for the data-memory arbiter
package dm_bus_arbiter_pkg;
  typedef enum logic {OWN_CPU = 1'b0, OWN_AUX = 1'b1} owner_e;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam logic [3:0] BYTEEN_RD = 4'b0000;
endpackage

// File: rtl/dm_arb_mux.sv
// dm_arb_mux: owner-select of address/data/byte-enables; a master without a live request can never drive a write
module dm_arb_mux
  import dm_bus_arbiter_pkg::*;
(
  input  logic        i_sel,
  input  logic        i_cpu_req,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [3:0]  i_cpu_byteen,
  input  logic        i_aux_req,
  input  logic [31:0] i_aux_addr,
  input  logic [31:0] i_aux_wdata,
  input  logic [3:0]  i_aux_byteen,
  output logic [31:0] o_addr,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_byteen
);
  logic w_aux;
  assign w_aux = i_sel == OWN_AUX;
  // steer the owner's request onto the bridge, gating byte enables with its req
  always_comb begin
    o_addr   = w_aux ? i_aux_addr : i_cpu_addr;
    o_wdata  = w_aux ? i_aux_wdata : i_cpu_wdata;
    o_byteen = w_aux ? (i_aux_req ? i_aux_byteen : BYTEEN_RD)
                     : (i_cpu_req ? i_cpu_byteen : BYTEEN_RD);
  end
endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: CPU-parked two-master data-memory arbiter with aux starvation pre-emption and burst cap (DM_ARB_PERF_EN adds perf counters)
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cpu_req,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [3:0]  i_cpu_byteen,
  output logic        o_cpu_ack,
  output logic [31:0] o_cpu_rdata,
  input  logic        i_aux_req,
  input  logic        i_aux_lock,
  input  logic [31:0] i_aux_addr,
  input  logic [31:0] i_aux_wdata,
  input  logic [3:0]  i_aux_byteen,
  output logic        o_aux_ack,
  output logic [31:0] o_aux_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_byteen,
  input  logic [31:0] i_mem_rdata,
  output logic        o_owner
`ifdef DM_ARB_PERF_EN
  ,
  output logic [31:0] o_perf_cpu_stall,
  output logic [31:0] o_perf_aux_beats
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic          r_owner;
  logic          w_owner_nxt;
  logic [SW-1:0] r_starve;
  logic [BW-1:0] r_beat;
  logic          w_starved;
  logic          w_last;
  logic [3:0]    w_byteen;
  assign w_starved = r_starve == SW'(STARVE_LIMIT);
  assign w_last    = r_beat == BW'(MAX_BURST - 1);
  dm_arb_mux u_mux (
    .i_sel        (r_owner),
    .i_cpu_req    (i_cpu_req),
    .i_cpu_addr   (i_cpu_addr),
    .i_cpu_wdata  (i_cpu_wdata),
    .i_cpu_byteen (i_cpu_byteen),
    .i_aux_req    (i_aux_req),
    .i_aux_addr   (i_aux_addr),
    .i_aux_wdata  (i_aux_wdata),
    .i_aux_byteen (i_aux_byteen),
    .o_addr       (o_mem_addr),
    .o_wdata      (o_mem_wdata),
    .o_byteen     (w_byteen)
  );
  assign o_mem_byteen = w_byteen & {4{i_reset_n}};
  assign o_cpu_rdata  = i_mem_rdata;
  assign o_aux_rdata  = i_mem_rdata;
  assign o_owner      = r_owner;
  // ownership register, parked on the CPU out of reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_owner <= OWN_CPU;
    else            r_owner <= w_owner_nxt;
  end
  // hand over to aux when the CPU is idle or aux has starved; return on drop, yield, or burst cap
  always_comb begin
    w_owner_nxt = r_owner;
    if (r_owner == OWN_CPU)
      w_owner_nxt = (i_aux_req && (!i_cpu_req || w_starved)) ? OWN_AUX : OWN_CPU;
    else
      w_owner_nxt = (!i_aux_req || (o_aux_ack && (w_last || (!i_aux_lock && i_cpu_req)))) ? OWN_CPU : OWN_AUX;
  end
  // acks only for the owner's live request, and never while reset is held
  always_comb begin
    o_cpu_ack = i_reset_n && r_owner == OWN_CPU && i_cpu_req;
    o_aux_ack = i_reset_n && r_owner == OWN_AUX && i_aux_req;
  end
  // saturating aux wait counter and per-tenure beat counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve <= '0;
      r_beat   <= '0;
    end else begin
      r_starve <= (!i_aux_req || o_aux_ack) ? '0
                : (r_owner == OWN_CPU && !w_starved) ? r_starve + SW'(1) : r_starve;
      r_beat   <= (r_owner == OWN_CPU) ? '0 : o_aux_ack ? r_beat + BW'(1) : r_beat;
    end
  end
`ifdef DM_ARB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_beats;
  assign o_perf_cpu_stall = r_perf_stall;
  assign o_perf_aux_beats = r_perf_beats;
  // free-running CPU stall and aux beat counters, wrapping at 2^32
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_perf_stall <= '0;
      r_perf_beats <= '0;
    end else begin
      if (i_cpu_req && !o_cpu_ack) r_perf_stall <= r_perf_stall + 32'd1;
      if (o_aux_ack)               r_perf_beats <= r_perf_beats + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: directed scoreboard bench for dm_bus_arbiter
module tb_dm_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, aux_req, aux_lock;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [3:0]  cpu_be, aux_be;
  logic        cpu_ack, aux_ack, owner;
  logic [31:0] cpu_rdata, aux_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef DM_ARB_PERF_EN
  logic [31:0] perf_stall, perf_beats;
`endif
  int total = 0;
  int bad = 0;
  int cyc = 0;
  typedef struct {
    bit          who;
    int          cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] rd;
  } exp_t;
  exp_t q[$];

  dm_bus_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .i_cpu_byteen(cpu_be),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .i_aux_req(aux_req), .i_aux_lock(aux_lock), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
    .i_aux_byteen(aux_be), .o_aux_ack(aux_ack), .o_aux_rdata(aux_rdata),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_byteen(mem_be),
    .i_mem_rdata(mem_rdata), .o_owner(owner)
`ifdef DM_ARB_PERF_EN
    , .o_perf_cpu_stall(perf_stall), .o_perf_aux_beats(perf_beats)
`endif
  );

  assign mem_rdata = (mem_addr == 32'h0000_2000) ? 32'hDEAD_BEEF : ~mem_addr;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic push(input bit who, input int c, input logic [31:0] a, input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.who = who; e.cyc = c; e.addr = a; e.be = be; e.rd = rd;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("dual_ack", {31'd0, cpu_ack & aux_ack}, 32'd0);
    if (cpu_ack || aux_ack) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: cpu_ack=%b aux_ack=%b with empty scoreboard (cycle %0d)", cpu_ack, aux_ack, cyc);
      end else begin
        e = q.pop_front();
        chk("ack_master", {31'd0, aux_ack}, {31'd0, e.who});
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_addr", mem_addr, e.addr);
        chk("ack_byteen", {28'd0, mem_be}, {28'd0, e.be});
        chk("ack_rdata", aux_ack ? aux_rdata : cpu_rdata, e.rd);
      end
    end
  end

  initial begin
    int s;
    rst_n = 1'b0; aux_lock = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'hF;
    aux_req = 1'b1; aux_addr = 32'h0; aux_wdata = 32'h0; aux_be = 4'hF;
    #2;
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_aux_ack", {31'd0, aux_ack}, 32'd0);
    chk("rst_byteen", {28'd0, mem_be}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0; aux_req = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    cpu_req = 1'b1; cpu_addr = 32'h0000_1000; cpu_be = 4'hF; cpu_wdata = 32'h1234_5678;
    push(1'b0, s, 32'h0000_1000, 4'hF, 32'hFFFF_EFFF);
    @(negedge clk);
    chk("cpu_wdata", mem_wdata, 32'h1234_5678);
    chk("cpu_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    aux_req = 1'b1; aux_addr = 32'h0000_2000; aux_be = 4'h0;
    push(1'b1, s + 1, 32'h0000_2000, 4'h0, 32'hDEAD_BEEF);
    push(1'b0, s + 3, 32'h0000_7000, 4'hF, 32'hFFFF_8FFF);
    @(negedge clk);
    chk("aux_handover_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    chk("aux_owner", {31'd0, owner}, 32'd1);
    @(posedge clk); #1;
    aux_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h0000_7000; cpu_be = 4'hF;
    @(negedge clk);
    chk("nonowner_byteen", {28'd0, mem_be}, 32'd0);
    chk("nonowner_stall", {31'd0, cpu_ack}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    cpu_req = 1'b1; cpu_addr = 32'h0000_3000; cpu_be = 4'h0;
    aux_req = 1'b1; aux_addr = 32'h0000_4000; aux_be = 4'h3; aux_wdata = 32'hCAFE_0001;
    for (int i = 0; i < 9; i++) push(1'b0, s + i, 32'h0000_3000, 4'h0, 32'hFFFF_CFFF);
    push(1'b1, s + 9, 32'h0000_4000, 4'h3, 32'hFFFF_BFFF);
    push(1'b0, s + 10, 32'h0000_3000, 4'h0, 32'hFFFF_CFFF);
    repeat (10) @(posedge clk);
    #1;
    aux_req = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    aux_req = 1'b1; aux_lock = 1'b1; aux_addr = 32'h0000_5000; aux_be = 4'h1; aux_wdata = 32'h5555_AAAA;
    cpu_addr = 32'h0000_6000; cpu_be = 4'hF;
    for (int i = 1; i <= 4; i++) push(1'b1, s + i, 32'h0000_5000, 4'h1, 32'hFFFF_AFFF);
    push(1'b0, s + 5, 32'h0000_6000, 4'hF, 32'hFFFF_9FFF);
    @(posedge clk); #1;
    cpu_req = 1'b1;
    @(negedge clk);
    chk("burst_block_byteen", {28'd0, mem_be}, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("burst_release_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b0; aux_req = 1'b0; aux_lock = 1'b0;
    @(posedge clk); #1;
`ifdef DM_ARB_PERF_EN
    chk("perf_stall", perf_stall, 32'd6);
    chk("perf_beats", perf_beats, 32'd6);
`endif
    s = cyc;
    aux_req = 1'b1; aux_lock = 1'b1; aux_addr = 32'h0000_8000; aux_be = 4'hF; aux_wdata = 32'h0BAD_F00D;
    push(1'b1, s + 1, 32'h0000_8000, 4'hF, 32'hFFFF_7FFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_owner", {31'd0, owner}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_byteen", {28'd0, mem_be}, 32'd0);
    chk("async_aux_ack", {31'd0, aux_ack}, 32'd0);
    chk("async_owner", {31'd0, owner}, 32'd0);
`ifdef DM_ARB_PERF_EN
    chk("async_perf_stall", perf_stall, 32'd0);
    chk("async_perf_beats", perf_beats, 32'd0);
`endif
    @(posedge clk); #1;
    aux_req = 1'b0; aux_lock = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_owner", {31'd0, owner}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_left", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
